// File: rtl/fx3_pkg.sv
// Shared FX3 egress types and constants.
// Packer FSM encoding, datapath widths and bus block sizes.
package fx3_pkg;

    localparam int FX3_DATA_W   = 32;
    localparam int FX3_SIZE_W   = 24;
    localparam int FX3_BLK_USB2 = 128;
    localparam int FX3_BLK_USB3 = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLOSE = 2'd2,
        ST_GAP   = 2'd3
    } fx3_state_e;

endpackage

// File: rtl/fx3_egress_packer.sv
// Packs a valid/ready word stream into FX3 ping-pong FIFO blocks,
// committing on full, on last, or after an idle timeout.
module fx3_egress_packer
    import fx3_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64,
    parameter int SIZE_W        = FX3_SIZE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_egress_ready,
    output logic [1:0]            o_egress_activate,
    input  logic [SIZE_W-1:0]     i_egress_size,
    output logic [FX3_DATA_W-1:0] o_egress_data,
    output logic                  o_egress_strobe,
    input  logic [FX3_DATA_W-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic [15:0]           o_block_count
);

    localparam int TMR_W =
        (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(FLUSH_TIMEOUT);

    fx3_state_e            state_q, state_d;
    logic [1:0]            act_q, act_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [SIZE_W-1:0]     count_q, count_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [FX3_DATA_W-1:0] data_q, data_d;
    logic                  stb_q, stb_d;
    logic [15:0]           bcnt_q, bcnt_d;

    logic              accept;
    logic [SIZE_W-1:0] count_inc;

    assign o_ready   = (state_q == ST_FILL) && (count_q < size_q);
    assign accept    = i_valid && o_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        size_d  = size_q;
        count_d = count_q;
        timer_d = timer_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (act_q == 2'b00 && i_egress_ready != 2'b00 &&
                    i_egress_size != '0) begin
                    act_d   = i_egress_ready[0] ? 2'b01 : 2'b10;
                    size_d  = i_egress_size;
                    count_d = '0;
                    timer_d = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    data_d  = i_data;
                    stb_d   = 1'b1;
                    count_d = count_inc;
                    timer_d = '0;
                    if (count_inc == size_q || i_last) begin
                        state_d = ST_CLOSE;
                    end
                end else if (count_q != '0 && FLUSH_TIMEOUT != 0) begin
                    // An empty open block never flushes.
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMR_END) begin
                        state_d = ST_CLOSE;
                    end
                end
            end
            ST_CLOSE: begin
                act_d   = 2'b00;
                bcnt_d  = bcnt_q + 16'd1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            size_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            size_q  <= size_d;
            count_q <= count_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign o_egress_activate = act_q;
    assign o_egress_data     = data_q;
    assign o_egress_strobe   = stb_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_block_count     = bcnt_q;

endmodule
